adap_sped_ctl: RTL and testbench
================================

Name: adap_sped_ctl

Overview:
- G.721/G.726 ADPCM adaptation speed control block.
- Each sample, it updates the short-term average magnitude DMS, the long-term average magnitude DML and the unlimited speed control parameter AP.
- It outputs the limited speed control parameter AL, which the quantizer scale-factor block consumes.
- All state flops form one mux-D scan chain.

Parameters:
- None. All widths are fixed by G.721.

Ports:
- clk  in  1  system clock; all flops update on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; state updates only on cycles with en=1.
- i  in  4  ADPCM codeword I.
- y  in  13  quantizer scale factor Y, unsigned.
- tdp  in  1  tone-detect flag TDP.
- tr  in  1  transition-detect flag TR.
- al  out  7  limited speed control AL.
- scan_in0  in  1  scan chain serial input.
- scan_en  in  1  scan shift enable.
- scan_out0  out  1  scan chain serial output.

Behaviour:
- State registers: dms[11:0], dml[13:0], ap[9:0]. All are 0 after reset; therefore al=0 and scan_out0=0 after reset.
- Clock-edge priority: reset > scan_en > en > hold.
- FUNCTF:
  - mag = i[3] ? ~i[2:0] : i[2:0].
  - fi = 7 for mag 7; 3 for mag 6; 1 for mag 3–5; 0 for mag 0–2.
- FILTA: dmsp = (dms + ((fi<<9) - dms) >>> 5) mod 4096. The difference is 13-bit two's complement; >>> is an arithmetic shift.
- FILTB: dmlp = (dml + ((fi<<11) - dml) >>> 7) mod 16384. The difference is 15-bit two's complement.
- SUBTC:
  - dif = (dmsp<<2) - dmlp, 15-bit two's complement; difm = |dif|.
  - dthr = dmlp>>3.
  - ax = 0 iff (difm < dthr) AND (y >= 1536) AND (tdp == 0); otherwise ax = 1.
- FILTC: app = (ap + ((ax<<9) - ap) >>> 4) mod 1024. The difference is 11-bit two's complement.
- TRIGA: apr = tr ? 256 : app.
- Sample update (en=1, scan_en=0, reset=0): dms<=dmsp, dml<=dmlp, ap<=apr.
- LIMA: al = (ap >= 256) ? 64 : ap[9:2].
  - al is purely combinational from the ap register.
  - al reflects the new AP one cycle after the en edge and is valid at all times.
- Boundary conditions:
  - ap saturates naturally: repeated ax=1 converges toward 512, and al stays 64 while ap ≥ 256.
  - tr overrides ax in the same cycle.
  - en is ignored while scan_en=1.
  - reset asserted mid-operation clears all state on the next edge regardless of en or scan_en.

Optional Feature:
- Macro: ADAP_SCAN_CHAIN_EN.
- Defined:
  - chain[35:0] = {dms[11:0], dml[13:0], ap[9:0]}.
  - When scan_en=1 and reset=0, each edge performs chain <= {chain[34:0], scan_in0}.
  - scan_out0 = chain[35] (dms[11]), combinational from the flop.
  - After 36 shifts the previous contents have emerged MSB-first and the new contents are loaded.
- Undefined:
  - scan_en and scan_in0 are ignored.
  - scan_out0 is tied to 0.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset: reset=1 for one edge -> al=0, scan_out0=0, internal state all 0.
- Single update from reset: i=4'b0111 (fi=7), y=1536, tdp=0, tr=0, en=1 for one edge -> dms=112, dml=112, ap=32 (ax=1, difm=336 ≥ dthr=14); al=8.
- Transition override: from any state, tr=1, en=1 -> ap=256, al=64. Then hold en=0 for several cycles -> al remains 64.
- AX=0 path (scan build):
  - Scan-load dms=256, dml=1024, ap=256.
  - Apply i=0, y=1536, tdp=0, en=1 -> dmsp=248, dmlp=1016, difm=24 < dthr=127 so ax=0; ap=240, al=60.
  - Repeat with y=1535 -> ax=1, ap=256+16=272, al=64.
- Scan shift:
  - After the single-update state, scan_en=1 with scan_in0=1 for 36 edges.
  - scan_out0 sequence equals {12'd112, 14'd112, 10'd32}, MSB first.
  - Afterwards dms=4095, dml=16383, ap=1023, al=64.
- Enable gating: en=0 with varying i/y/tr for 10 cycles -> state and al unchanged. Then reset asserted concurrently with en=1 -> state cleared to 0.

Source files
------------

// File: rtl/adap_sped_ctl_if.sv
// Sample-rate signal bundle for the ADPCM adaptation speed control block.
// The master side drives codeword, scale factor, flags and scan controls.
interface adap_sped_ctl_if;
  logic        en;
  logic [3:0]  i;
  logic [12:0] y;
  logic        tdp;
  logic        tr;
  logic [6:0]  al;
  logic        scan_in0;
  logic        scan_en;
  logic        scan_out0;

  modport master (
    output en, i, y, tdp, tr, scan_in0, scan_en,
    input  al, scan_out0
  );

  modport slave (
    input  en, i, y, tdp, tr, scan_in0, scan_en,
    output al, scan_out0
  );
endinterface

// File: rtl/adap_sped_ctl.sv
// G.721/G.726 adaptation speed control: tracks DMS, DML and AP and produces the limited AL.
// Optional ADAP_SCAN_CHAIN_EN builds the 36-bit state scan chain {dms, dml, ap}.
module adap_sped_ctl (
  input logic            clk,
  input logic            reset,
  adap_sped_ctl_if.slave bus
);

  logic [11:0] dms_q, dms_d;
  logic [13:0] dml_q, dml_d;
  logic [9:0]  ap_q, ap_d;

  logic [2:0]         mag, fi;
  logic signed [12:0] dif_a, sh_a;
  logic signed [14:0] dif_b, sh_b;
  logic signed [14:0] dif_c;
  logic signed [10:0] dif_f, sh_f;
  logic [11:0]        dmsp;
  logic [13:0]        dmlp;
  logic [14:0]        difm;
  logic [10:0]        dthr;
  logic               ax;
  logic [9:0]         app, apr;
  logic               upd;

  always_comb begin
    mag = bus.i[3] ? ~bus.i[2:0] : bus.i[2:0];
    case (mag)
      3'd7:                fi = 3'd7;
      3'd6:                fi = 3'd3;
      3'd5, 3'd4, 3'd3:    fi = 3'd1;
      default:             fi = 3'd0;
    endcase

    dif_a = $signed({1'b0, fi, 9'd0}) - $signed({1'b0, dms_q});
    sh_a  = dif_a >>> 5;
    dmsp  = dms_q + sh_a[11:0];

    dif_b = $signed({1'b0, fi, 11'd0}) - $signed({1'b0, dml_q});
    sh_b  = dif_b >>> 7;
    dmlp  = dml_q + sh_b[13:0];

    dif_c = $signed({1'b0, dmsp, 2'b00}) - $signed({1'b0, dmlp});
    difm  = dif_c[14] ? (15'd0 - dif_c) : dif_c;
    dthr  = dmlp[13:3];
    // Slow adaptation only for a stationary, non-tone signal at a large enough scale.
    ax    = ~((difm < {4'd0, dthr}) && (bus.y >= 13'd1536) && !bus.tdp);

    dif_f = $signed({1'b0, ax, 9'd0}) - $signed({1'b0, ap_q});
    sh_f  = dif_f >>> 4;
    app   = ap_q + sh_f[9:0];
    apr   = bus.tr ? 10'd256 : app;
  end

`ifdef ADAP_SCAN_CHAIN_EN
  assign upd           = bus.en & ~bus.scan_en;
  assign bus.scan_out0 = dms_q[11];
`else
  logic unused_scan;
  assign unused_scan   = bus.scan_en ^ bus.scan_in0;
  assign upd           = bus.en;
  assign bus.scan_out0 = 1'b0;
`endif

  always_comb begin
    dms_d = dms_q;
    dml_d = dml_q;
    ap_d  = ap_q;
`ifdef ADAP_SCAN_CHAIN_EN
    if (bus.scan_en) begin
      {dms_d, dml_d, ap_d} = {dms_q[10:0], dml_q, ap_q, bus.scan_in0};
    end else
`endif
    if (upd) begin
      dms_d = dmsp;
      dml_d = dmlp;
      ap_d  = apr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dms_q <= '0;
      dml_q <= '0;
      ap_q  <= '0;
    end else begin
      dms_q <= dms_d;
      dml_q <= dml_d;
      ap_q  <= ap_d;
    end
  end

  assign bus.al = (ap_q[9] | ap_q[8]) ? 7'd64 : {1'b0, ap_q[7:2]};

endmodule

// File: tb/tb_adap_sped_ctl.sv
// Directed self-checking bench for adap_sped_ctl; scan cases build with ADAP_SCAN_CHAIN_EN.
module tb_adap_sped_ctl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  adap_sped_ctl_if bus_if ();

  adap_sped_ctl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int dms, input int dml, input int ap,
                             input int al);
    check_val({tag, ".dms"}, 64'(dut.dms_q), 64'(dms));
    check_val({tag, ".dml"}, 64'(dut.dml_q), 64'(dml));
    check_val({tag, ".ap"},  64'(dut.ap_q),  64'(ap));
    check_val({tag, ".al"},  64'(bus_if.al), 64'(al));
  endtask

  task automatic do_sample(input logic [3:0] iv, input logic [12:0] yv, input logic tdpv,
                           input logic trv);
    bus_if.i   = iv;
    bus_if.y   = yv;
    bus_if.tdp = tdpv;
    bus_if.tr  = trv;
    bus_if.en  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.en  = 1'b0;
    bus_if.tr  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

`ifdef ADAP_SCAN_CHAIN_EN
  task automatic scan_load(input logic [35:0] v);
    bus_if.scan_en = 1'b1;
    bus_if.en      = 1'b1;
    for (int k = 35; k >= 0; k--) begin
      bus_if.scan_in0 = v[k];
      @(posedge clk);
      #1;
    end
    bus_if.scan_en  = 1'b0;
    bus_if.en       = 1'b0;
    bus_if.scan_in0 = 1'b0;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_bad = 0;
    bus_if.en       = 1'b0;
    bus_if.i        = 4'd0;
    bus_if.y        = 13'd0;
    bus_if.tdp      = 1'b0;
    bus_if.tr       = 1'b0;
    bus_if.scan_in0 = 1'b0;
    bus_if.scan_en  = 1'b0;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check_state("reset", 0, 0, 0, 0);
    check_val("reset.scan_out0", 64'(bus_if.scan_out0), 64'd0);

    // Hand-computed trajectory through fi = 7, 7, 0, 3 (i=1001), 1 with TR.
    do_sample(4'b0111, 13'd1536, 1'b0, 1'b0);
    check_state("s1", 112, 112, 32, 8);
    do_sample(4'b0111, 13'd1536, 1'b0, 1'b0);
    check_state("s2", 220, 223, 62, 15);
    do_sample(4'b0000, 13'd1536, 1'b0, 1'b0);
    check_state("s3", 213, 221, 90, 22);
    do_sample(4'b1001, 13'd1536, 1'b0, 1'b0);
    check_state("s4", 254, 267, 116, 29);
    do_sample(4'b0011, 13'd1536, 1'b0, 1'b1);
    check_state("tr", 262, 280, 256, 64);

    for (int c = 0; c < 10; c++) begin
      bus_if.i   = 4'(c * 3 + 1);
      bus_if.y   = 13'(c * 700);
      bus_if.tr  = c[0];
      bus_if.tdp = c[1];
      @(posedge clk);
      #1;
      check_val("hold.al", 64'(bus_if.al), 64'd64);
    end
    bus_if.tr  = 1'b0;
    bus_if.tdp = 1'b0;
    check_state("hold", 262, 280, 256, 64);

    do_sample(4'b0000, 13'd1536, 1'b0, 1'b0);
    check_state("sat1", 253, 277, 272, 64);
    do_sample(4'b0000, 13'd1536, 1'b0, 1'b0);
    check_state("sat2", 245, 274, 287, 64);

`ifdef ADAP_SCAN_CHAIN_EN
    begin
      logic [35:0] seen;
      logic [35:0] exp_chain;
      exp_chain = {12'd112, 14'd112, 10'd32};
      do_reset();
      do_sample(4'b0111, 13'd1536, 1'b0, 1'b0);
      bus_if.scan_en  = 1'b1;
      bus_if.scan_in0 = 1'b1;
      for (int k = 35; k >= 0; k--) begin
        seen[k] = bus_if.scan_out0;
        @(posedge clk);
        #1;
      end
      bus_if.scan_en  = 1'b0;
      bus_if.scan_in0 = 1'b0;
      check_val("scan.out", 64'(seen), 64'(exp_chain));
      check_state("scan.ones", 4095, 16383, 1023, 64);

      scan_load({12'd256, 14'd1024, 10'd256});
      check_state("scan.load", 256, 1024, 256, 64);
      do_sample(4'b0000, 13'd1536, 1'b0, 1'b0);
      check_state("ax0", 248, 1016, 240, 60);
      scan_load({12'd256, 14'd1024, 10'd256});
      do_sample(4'b0000, 13'd1535, 1'b0, 1'b0);
      check_state("ax1.y", 248, 1016, 272, 64);
    end
`endif

    // Steady fi=7 input: DMS*4 and DML converge, so AX drops to 0 and AP decays to 0.
    do_reset();
    for (int n = 0; n < 500; n++) do_sample(4'b0111, 13'd1536, 1'b0, 1'b0);
    check_val("steady.ap", 64'(dut.ap_q), 64'd0);
    check_val("steady.al", 64'(bus_if.al), 64'd0);
    do_sample(4'b0111, 13'd1535, 1'b0, 1'b0);
    check_val("ybound.ap", 64'(dut.ap_q), 64'd32);
    check_val("ybound.al", 64'(bus_if.al), 64'd8);
    do_sample(4'b0111, 13'd1536, 1'b1, 1'b0);
    check_val("tdp.ap", 64'(dut.ap_q), 64'd62);
    check_val("tdp.al", 64'(bus_if.al), 64'd15);
    do_sample(4'b0111, 13'd1536, 1'b0, 1'b0);
    check_val("decay.ap", 64'(dut.ap_q), 64'd58);
    check_val("decay.al", 64'(bus_if.al), 64'd14);

    bus_if.i  = 4'b0111;
    bus_if.y  = 13'd1536;
    bus_if.en = 1'b1;
`ifdef ADAP_SCAN_CHAIN_EN
    bus_if.scan_en = 1'b1;
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus_if.en      = 1'b0;
    bus_if.scan_en = 1'b0;
    check_state("midrst", 0, 0, 0, 0);
    check_val("midrst.scan_out0", 64'(bus_if.scan_out0), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
